// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern-scan controller: state encoding and
// the width of the pattern-length field.
package seq_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    SCAN  = ST_SCAN,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to hold a pattern length in the range 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial matcher: history shift register, bits-since-clear counter and masked
// compare. Optional macro NON_OVERLAP_EN makes a hit restart the history.
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  logic [PAT_W-1:0] hist_q, hist_d, hist_cur, mask;
  logic [LEN_W-1:0] since_q, since_d, since_cur;

  always_comb begin
    hist_cur  = {hist_q[PAT_W-2:0], bit_in};
    // The counter only has to prove that len bits were seen, so it stops at PAT_W.
    since_cur = (since_q == LEN_W'(PAT_W)) ? since_q : since_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (int'(len) > i);
    end
    hit = shift && (((hist_cur ^ pattern) & mask) == '0) && (since_cur >= len);

    hist_d  = hist_q;
    since_d = since_q;
    if (clr) begin
      hist_d  = '0;
      since_d = '0;
    end else if (shift) begin
      hist_d  = hist_cur;
      since_d = since_cur;
`ifdef NON_OVERLAP_EN
      if (hit) begin
        hist_d  = '0;
        since_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) since_q <= '0;
    else       since_q <= since_d;
  end

  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Programmable serial pattern-scan controller: config handshake, scan FSM,
// registered match pulse and saturating match counter. Honors NON_OVERLAP_EN.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int NB_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [len_w(PAT_W)-1:0]  cfg_len,
  input  logic [NB_W-1:0]          cfg_nbits,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int LEN_W = len_w(PAT_W);

  state_t           state_q, state_d;
  logic             match_q, match_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [NB_W-1:0]  nbits_q, nbits_d;
  logic [NB_W-1:0]  bits_q, bits_d;
  logic             cfg_legal, launch, core_shift, hit;

  assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  // Config has priority over start; abort has priority over both.
  assign launch     = !abort && !cfg_valid && start && (state_q == ARMED || state_q == DONE);
  assign core_shift = !abort && (state_q == SCAN) && bit_valid;

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (launch),
    .shift   (core_shift),
    .bit_in  (bit_in),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_comb begin
    state_d   = state_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    nbits_d   = nbits_q;
    bits_d    = bits_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ARMED, DONE: begin
          if (cfg_valid) begin
            if (cfg_legal) begin
              pat_d   = cfg_pattern;
              len_d   = cfg_len;
              nbits_d = cfg_nbits;
              state_d = ARMED;
            end else begin
              cfg_err_d = 1'b1;
              state_d   = IDLE;
            end
          end else if (launch) begin
            cnt_d   = '0;
            bits_d  = '0;
            state_d = (nbits_q == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (bit_valid) begin
            bits_d = bits_q + NB_W'(1);
            if (hit) begin
              match_d = 1'b1;
              cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
            if (bits_q + NB_W'(1) == nbits_q) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      nbits_q   <= '0;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      nbits_q   <= nbits_d;
      bits_q    <= bits_d;
    end
  end

  assign cfg_ready   = (state_q != SCAN);
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus randomized scans
// checked every cycle against a queue-based behavioural model.
module tb_seq_scan_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int NB_W  = 16;
  localparam int LEN_W = $clog2(PAT_W + 1);

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_SCAN  = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             reset, cfg_valid, start, abort, bit_valid, bit_in;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [NB_W-1:0]  cfg_nbits;
  logic             cfg_ready, match, busy, done, cfg_err;
  logic [CNT_W-1:0] match_count;

  int tests = 0;
  int fails = 0;

  int               m_mode, m_len, m_nbits, m_seen, m_cnt;
  logic [PAT_W-1:0] m_pat;
  bit               m_match, m_err;
  bit               hq[$];

  always #5 clk = ~clk;

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .NB_W(NB_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_nbits   (cfg_nbits),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Did the most recent m_len received bits spell the pattern (newest = bit 0)?
  function automatic bit tail_hit();
    if (hq.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (hq[hq.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit legal;
    legal   = (cfg_len >= 1) && (cfg_len <= PAT_W);
    m_match = 1'b0;
    m_err   = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_pat = '0; m_len = 0; m_nbits = 0; m_seen = 0;
      hq.delete();
    end else if (abort) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_SCAN) begin
      if (bit_valid) begin
        hq.push_back(bit_in);
        m_seen++;
        if (tail_hit()) begin
          m_match = 1'b1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifdef NON_OVERLAP_EN
          hq.delete();
`endif
        end
        if (m_seen == m_nbits) m_mode = M_DONE;
      end
    end else if (cfg_valid) begin
      if (legal) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_nbits = int'(cfg_nbits);
        m_mode = M_ARMED;
      end else begin
        m_err  = 1'b1;
        m_mode = M_IDLE;
      end
    end else if (start && m_mode != M_IDLE) begin
      hq.delete();
      m_seen = 0;
      m_cnt  = 0;
      m_mode = (m_nbits == 0) ? M_DONE : M_SCAN;
    end
  endtask

  task automatic check_all();
    chk("match",       match,       m_match);
    chk("match_count", match_count, m_cnt);
    chk("busy",        busy,        m_mode == M_SCAN);
    chk("done",        done,        m_mode == M_DONE);
    chk("cfg_ready",   cfg_ready,   m_mode != M_SCAN);
    chk("cfg_err",     cfg_err,     m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    reset = 0; cfg_valid = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic [NB_W-1:0] n);
    quiet(); cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_nbits = n;
    tick(); quiet();
  endtask

  task automatic do_start();
    quiet(); start = 1; tick(); quiet();
  endtask

  task automatic send(input logic v, input logic b);
    quiet(); bit_valid = v; bit_in = b; tick(); quiet();
  endtask

  initial begin
    logic [7:0] seq1;
    quiet();
    cfg_pattern = '0; cfg_len = '0; cfg_nbits = '0;
    reset = 1;
    tick(); tick();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_count", match_count, 0);
    quiet();

    // Scenario 1: 101 over 0,1,0,1,0,1,1,0 (first-sent bit is seq1[7])
    seq1 = 8'b0101_0110;
    do_cfg(8'b101, 3, 8);
    do_start();
    for (int i = 7; i >= 0; i--) send(1, seq1[i]);
`ifdef NON_OVERLAP_EN
    chk("t1_count", match_count, 1);
`else
    chk("t1_count", match_count, 2);
`endif
    chk("t1_done", done, 1);

    // Scenario 2: same bits, invalid cycles interleaved, config retained
    do_start();
    for (int i = 7; i >= 0; i--) begin
      send(0, 1'($urandom));
      send(1, seq1[i]);
    end
`ifdef NON_OVERLAP_EN
    chk("t2_count", match_count, 1);
`else
    chk("t2_count", match_count, 2);
`endif

    // Scenario 3: zero length rejected, later start ignored
    do_cfg(8'h5, 0, 8);
    chk("t3_err", cfg_err, 1);
    do_start();
    chk("t3_busy", busy, 0);

    // Scenario 4: abort after three bits
    do_cfg(8'b101, 3, 8);
    do_start();
    send(1, 1); send(1, 0); send(1, 1);
    quiet(); abort = 1; tick(); quiet();
    chk("t4_busy", busy, 0);
    chk("t4_count", match_count, 1);
    chk("t4_ready", cfg_ready, 1);
    chk("t4_done", done, 0);

    // Scenario 5: counter saturation over 300 ones
    do_cfg(8'b1, 1, 300);
    do_start();
    for (int i = 0; i < 300; i++) send(1, 1);
    chk("t5_count", match_count, 255);
    chk("t5_done", done, 1);

    // Scenario 6: reset mid-scan, then unconfigured start
    do_cfg(8'b101, 3, 8);
    do_start();
    send(1, 1); send(1, 0); send(1, 1);
    quiet(); reset = 1; tick(); quiet();
    chk("t6_match", match, 0);
    chk("t6_busy", busy, 0);
    do_start();
    chk("t6_start_ignored", busy, 0);

    // Randomized scans, including illegal lengths, zero-length scans and aborts
    for (int r = 0; r < 40; r++) begin
      logic [LEN_W-1:0] l;
      l = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15)) * LEN_W'($urandom_range(0, 1))
                                      : LEN_W'($urandom_range(1, 4));
      do_cfg(PAT_W'($urandom), l, NB_W'($urandom_range(0, 40)));
      do_start();
      for (int c = 0; c < 120 && m_mode == M_SCAN; c++) begin
        quiet();
        bit_valid = ($urandom_range(0, 3) != 0);
        bit_in    = 1'($urandom);
        cfg_valid = ($urandom_range(0, 15) == 0);
        start     = ($urandom_range(0, 15) == 0);
        abort     = ($urandom_range(0, 63) == 0);
        cfg_len   = LEN_W'($urandom_range(0, 4));
        tick();
      end
      quiet();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
